hazard_stall_ctrl: RTL

- Pipeline hazard controller that drives the enable/flush inputs of the IF/ID and ID/EX pipeline registers and the PC enable.
- Detects load-use hazards and taken-branch wrong-path fetches.
- Tracks a multi-cycle mult/div unit with a busy FSM and stalls dependent HI/LO reads and new mult/div issues until the unit is free.

---
 rtl/hazard_stall_ctrl_if.sv | 32 +++
 rtl/hazard_stall_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for hazard_stall_ctrl: ID/EX hazard inputs and
// pipeline-register/PC control outputs.
interface hazard_stall_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_branch_taken;
  logic              id_md_start;
  logic              id_md_read;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_flush;
  logic              md_busy;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
           id_md_start, id_md_read,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken,
           id_md_start, id_md_read,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / taken-branch hazard control plus mult/div busy tracking.
// Optional stall/flush statistics counters built when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_events
);

  typedef enum logic {
    IDLE,
    MD_RUN
  } state_t;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load_use;
  logic             md_hazard;
  logic             busy;

  // Busy is masked during reset so a reset landing mid-operation reads idle at once.
  assign busy       = (state == MD_RUN) && !reset;
  assign hz.md_busy = busy;

  assign load_use  = hz.ex_mem_read && (hz.ex_rt != ZERO_REG) &&
                     ((hz.ex_rt == hz.id_rs) ||
                      (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
  assign md_hazard = busy && (hz.id_md_start || hz.id_md_read);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (hz.id_md_start && !hz.ex_branch_taken && !load_use) begin
          state_next = MD_RUN;
          cnt_next   = CNT_LOAD;
        end
      end
      MD_RUN: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hz.pc_en      = 1'b1;
    hz.ifid_en    = 1'b1;
    hz.ifid_flush = 1'b0;
    hz.idex_en    = 1'b1;
    hz.idex_flush = 1'b0;
    if (reset) begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.ifid_flush = 1'b1;
      hz.idex_en    = 1'b0;
      hz.idex_flush = 1'b1;
    end else if (hz.ex_branch_taken) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (load_use || md_hazard) begin
      hz.pc_en      = 1'b0;
      hz.ifid_en    = 1'b0;
      hz.idex_flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!hz.pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (hz.ex_branch_taken && (flush_events != '1)) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
